// File: rtl/sensor_poll_controller.sv
// AHB-Lite read master that snapshots the sensor manager's three registers and raises irq on a fork count change.
// Optional stop detection is compiled in with `define SENSOR_POLL_STOP_DETECT_EN.
module sensor_poll_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
  parameter int unsigned POLL_PERIOD = 32768,
  parameter int unsigned STOP_LIMIT  = 3000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        poll_now,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic [15:0] fork_count,
  output logic [15:0] crank_period,
  output logic [15:0] fork_period,
  output logic        snap_valid,
`ifdef SENSOR_POLL_STOP_DETECT_EN
  output logic        stopped,
`endif
  output logic        irq,
  input  logic        irq_clr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [23:0] TIMER_MAX = 24'(POLL_PERIOD - 1);
  localparam logic [15:0] STOP_LIM  = 16'(STOP_LIMIT);

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        pending_q, pending_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [15:0] fork_count_q, fork_count_d;
  logic [15:0] crank_period_q, crank_period_d;
  logic [15:0] fork_period_q, fork_period_d;
  logic        irq_q, irq_d;
  logic        stopped_q, stopped_d;
  logic        timer_wrap;
  logic        irq_set;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sh0_d          = sh0_q;
    sh1_d          = sh1_q;
    sh2_d          = sh2_q;
    fork_count_d   = fork_count_q;
    crank_period_d = crank_period_q;
    fork_period_d  = fork_period_q;
    stopped_d      = stopped_q;
    irq_set        = 1'b0;

    timer_wrap = enable && (timer_q == TIMER_MAX);
    timer_d    = (!enable || timer_wrap) ? 24'd0 : timer_q + 24'd1;
    // One-deep request flag: further requests while set simply merge into it.
    pending_d  = pending_q | timer_wrap | poll_now;

    unique case (state_q)
      S_IDLE: begin
        if (pending_d) begin
          pending_d = 1'b0;
          idx_d     = 2'd0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          case (idx_q)
            2'd0:    sh0_d = HRDATA[15:0];
            2'd1:    sh1_d = HRDATA[15:0];
            default: sh2_d = HRDATA[15:0];
          endcase
          if (idx_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        // All three outputs load together so software never sees a mixed snapshot.
        fork_count_d   = sh0_q;
        crank_period_d = sh1_q;
        fork_period_d  = sh2_q;
        stopped_d      = (sh1_q > STOP_LIM) || (sh2_q > STOP_LIM);
        irq_set        = (sh0_q != fork_count_q);
`ifdef SENSOR_POLL_STOP_DETECT_EN
        irq_set        = irq_set || (stopped_d != stopped_q);
`endif
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      pending_q      <= 1'b0;
      idx_q          <= '0;
      fork_count_q   <= '0;
      crank_period_q <= '0;
      fork_period_q  <= '0;
      stopped_q      <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      pending_q      <= pending_d;
      idx_q          <= idx_d;
      fork_count_q   <= fork_count_d;
      crank_period_q <= crank_period_d;
      fork_period_q  <= fork_period_d;
      stopped_q      <= stopped_d;
      irq_q          <= irq_d;
    end
  end

  // Shadows are only consumed after a full sequence, so they need no reset.
  always_ff @(posedge HCLK) begin
    sh0_q <= sh0_d;
    sh1_q <= sh1_d;
    sh2_q <= sh2_d;
  end

  assign bus_req      = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign HTRANS       = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR        = (state_q == S_ADDR) ? (BASE_ADDR + {28'd0, idx_q, 2'b00}) : 32'd0;
  assign HWRITE       = 1'b0;
  assign HSIZE        = 3'b010;
  assign snap_valid   = (state_q == S_DONE);
  assign fork_count   = fork_count_q;
  assign crank_period = crank_period_q;
  assign fork_period  = fork_period_q;
  assign irq          = irq_q;

  logic unused_hrdata_hi;
  assign unused_hrdata_hi = ^HRDATA[31:16];

`ifdef SENSOR_POLL_STOP_DETECT_EN
  assign stopped = stopped_q;
`else
  logic unused_stopped;
  assign unused_stopped = stopped_q;
`endif

endmodule

// File: tb/tb_sensor_poll_controller.sv
// Directed bench for sensor_poll_controller with a small AHB slave model and hand-computed expectations.
module tb_sensor_poll_controller;

  logic        HCLK = 1'b0;
  logic        HRESET, enable, poll_now, bus_gnt, irq_clr;
  logic        bus_req, HWRITE, HREADY, snap_valid, irq;
  logic [31:0] HADDR, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [15:0] fork_count, crank_period, fork_period;
`ifdef SENSOR_POLL_STOP_DETECT_EN
  logic        stopped;
`endif

  always #5 HCLK = ~HCLK;

  sensor_poll_controller #(.POLL_PERIOD(20)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .poll_now(poll_now),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HRDATA(HRDATA), .HREADY(HREADY),
    .fork_count(fork_count), .crank_period(crank_period), .fork_period(fork_period),
    .snap_valid(snap_valid),
`ifdef SENSOR_POLL_STOP_DETECT_EN
    .stopped(stopped),
`endif
    .irq(irq), .irq_clr(irq_clr)
  );

  // Slave model: register file plus optional wait states in the data phase of word 1.
  logic [15:0] r0 = 16'h0, r1 = 16'h0, r2 = 16'h0, hi = 16'h0;
  int          stall_cfg = 0;
  logic        dp_valid = 1'b0;
  logic [1:0]  dp_idx = 2'd0;
  int          stall_cnt = 0;

  assign HREADY = !(dp_valid && dp_idx == 2'd1 && stall_cnt < stall_cfg);
  assign HRDATA = {hi, (dp_idx == 2'd0) ? r0 : (dp_idx == 2'd1) ? r1 : r2};

  always @(posedge HCLK) begin
    if (HREADY) begin
      dp_valid  <= (HTRANS == 2'b10);
      dp_idx    <= HADDR[3:2];
      stall_cnt <= 0;
    end else begin
      stall_cnt <= stall_cnt + 1;
    end
  end

  int          cyc = 0;
  int          sv_count = 0, sv_last = 0, sv_prev = 0;
  int          addr_n = 0;
  logic [31:0] addr_log [0:7];

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (snap_valid) begin
      sv_prev  <= sv_last;
      sv_last  <= cyc;
      sv_count <= sv_count + 1;
    end
    if (HTRANS == 2'b10 && HREADY) begin
      addr_log[addr_n[2:0]] <= HADDR;
      addr_n <= addr_n + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Pulse poll_now, optionally hold the grant off, and report cycles until snap_valid.
  task automatic run_poll(input int gnt_delay, output int lat);
    poll_now = 1'b1;
    bus_gnt  = (gnt_delay == 0);
    tick();
    poll_now = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == gnt_delay + 1) bus_gnt = 1'b1;
      @(negedge HCLK);
      if (snap_valid) begin
        lat = n;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic wait_snaps(input int cnt);
    int target;
    target = sv_count + cnt;
    for (int n = 0; n < 200; n++) begin
      if (sv_count >= target) break;
      tick();
    end
    chk_val("snap_timeout", (sv_count >= target), 1);
  endtask

  initial begin
    int lat, a0, s0, bad;
    HRESET = 1'b1; enable = 1'b0; poll_now = 1'b0; bus_gnt = 1'b0; irq_clr = 1'b0;
    tick(); tick();
    chk_val("rst_htrans", HTRANS, 2'b00);
    chk_val("rst_haddr", HADDR, 32'h0);
    chk_val("rst_bus_req", bus_req, 0);
    chk_val("rst_outputs", {fork_count, crank_period}, 32'h0);
    chk_val("rst_fork_period", fork_period, 0);
    chk_val("rst_irq_sv", {irq, snap_valid}, 0);
    HRESET = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (HTRANS !== 2'b00 || bus_req !== 1'b0 || irq !== 1'b0 || snap_valid !== 1'b0 ||
          fork_count !== 16'h0) bad = 1;
    end
    chk_val("idle_quiet", bad, 0);

    r0 = 16'h0005; r1 = 16'h0123; r2 = 16'h0456; hi = 16'h0000;
    a0 = addr_n;
    run_poll(0, lat);
    chk_val("single_latency", lat, 8);
    chk_val("addr0", addr_log[a0 % 8], 32'h6000_0000);
    chk_val("addr1", addr_log[(a0 + 1) % 8], 32'h6000_0004);
    chk_val("addr2", addr_log[(a0 + 2) % 8], 32'h6000_0008);
    chk_val("single_fork_count", fork_count, 16'h0005);
    chk_val("single_crank", crank_period, 16'h0123);
    chk_val("single_fork_period", fork_period, 16'h0456);
    chk_val("single_irq", irq, 1);
    chk_val("hwrite_hsize", {HWRITE, HSIZE}, 4'b0010);

    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    chk_val("irq_clr", irq, 0);
    hi = 16'hFFFF; r1 = 16'h0ABC; r2 = 16'h0DEF; stall_cfg = 2;
    run_poll(5, lat);
    chk_val("wait_latency", lat, 15);
    chk_val("wait_crank", crank_period, 16'h0ABC);
    chk_val("wait_fork_period", fork_period, 16'h0DEF);
    chk_val("wait_fork_same", fork_count, 16'h0005);
    chk_val("wait_irq_same", irq, 0);
    stall_cfg = 0; hi = 16'h0000;

    enable = 1'b1;
    wait_snaps(3);
    chk_val("period_interval", sv_last - sv_prev, 20);
    chk_val("period_irq_same", irq, 0);
    r0 = 16'hFFFF;
    wait_snaps(1);
    tick();
    chk_val("period_ffff", fork_count, 16'hFFFF);
    chk_val("period_irq_set", irq, 1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    chk_val("period_irq_clr", irq, 0);
    r0 = 16'h0000;
    bad = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge HCLK);
      if (snap_valid) begin
        irq_clr = 1'b1;
        bad = 0;
        break;
      end
    end
    tick();
    irq_clr = 1'b0;
    chk_val("wrap_timeout", bad, 0);
    chk_val("wrap_fork_zero", fork_count, 16'h0000);
    chk_val("wrap_set_wins", irq, 1);
    enable = 1'b0;
    repeat (3) tick();

    s0 = sv_count;
    poll_now = 1'b1; tick(); poll_now = 1'b0; tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0; tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0; tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    repeat (40) tick();
    chk_val("coalesce_count", sv_count - s0, 2);
    chk_val("coalesce_back2back", sv_last - sv_prev, 9);

    poll_now = 1'b1; tick(); poll_now = 1'b0;
    repeat (4) tick();
    chk_val("mid_bus_req", bus_req, 1);
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    chk_val("mid_rst_htrans", HTRANS, 2'b00);
    chk_val("mid_rst_bus_req", bus_req, 0);
    chk_val("mid_rst_outputs", {fork_count, crank_period}, 32'h0);
    chk_val("mid_rst_fp_irq", {fork_period, irq}, 17'h0);
    s0 = sv_count;
    repeat (30) tick();
    chk_val("mid_rst_no_resume", sv_count - s0, 0);

    r0 = 16'h0000; r1 = 16'h0001; r2 = 16'h0002;
    run_poll(0, lat);
    chk_val("first_after_rst_lat", lat, 8);
    chk_val("first_after_rst_irq", irq, 0);
    chk_val("first_after_rst_crank", crank_period, 16'h0001);

`ifdef SENSOR_POLL_STOP_DETECT_EN
    r1 = 16'd3000;
    run_poll(0, lat);
    chk_val("stop_at_limit", {stopped, irq}, 2'b00);
    r1 = 16'd3001;
    run_poll(0, lat);
    chk_val("stop_above_limit", stopped, 1);
    chk_val("stop_irq", irq, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sensor_poll_controller.md
Name: sensor_poll_controller

Overview:
- AHB-Lite read master that periodically snapshots the sensor manager's three registers: fork count at +0x0, crank period at +0x4 and fork period at +0x8.
- Shares the slave bus with the CPU through a request/grant handshake to the bus arbiter.
- Publishes an atomic, coherent snapshot and raises a level interrupt when the fork count changes, so software no longer needs to poll.

Parameters:
- BASE_ADDR, 32'h6000_0000, base address of the sensor manager.
- POLL_PERIOD, 32768, HCLK cycles between automatic polls; legal range 8..2^24-1.
- STOP_LIMIT, 3000, period value (ms) above which a wheel or crank counts as stopped.

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  synchronous reset, active-high.
- enable  input  1  1 = periodic polling runs; 0 = timer held at 0.
- poll_now  input  1  single-cycle pulse requesting an immediate poll.
- bus_req  output  1  bus request to the arbiter.
- bus_gnt  input  1  bus grant from the arbiter.
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type: IDLE=00, NONSEQ=10.
- HWRITE  output  1  tied 0.
- HSIZE  output  3  tied 3'b010 (word).
- HRDATA  input  32  AHB read data; only [15:0] is used.
- HREADY  input  1  AHB ready.
- fork_count  output  16  snapshot of register +0x0.
- crank_period  output  16  snapshot of register +0x4.
- fork_period  output  16  snapshot of register +0x8.
- snap_valid  output  1  one-cycle pulse when the snapshot updates.
- irq  output  1  level interrupt.
- irq_clr  input  1  pulse that clears irq.

Behaviour:
- Reset (sampled on HCLK rise while HRESET=1):
  - State goes to IDLE; timer, pending and index are cleared.
  - HTRANS=IDLE, HADDR=0, bus_req=0.
  - All snapshot outputs = 0; snap_valid=0; irq=0.
  - Reset asserted mid-sequence abandons the sequence; partial shadow data is discarded.
- Timer:
  - Counts while enable=1; held at 0 when enable=0.
  - When it reaches POLL_PERIOD-1 it wraps to 0 and sets pending.
  - poll_now also sets pending.
  - pending is one-deep: requests arriving while pending is already set coalesce and are not counted.
- FSM:
  - IDLE: if pending, clear pending, set index k=0, go to REQ.
  - REQ: bus_req=1. Wait for bus_gnt=1, then go to ADDR.
  - ADDR: HTRANS=NONSEQ, HADDR=BASE_ADDR+4*k. When HREADY=1, go to DATA.
  - DATA: HTRANS=IDLE. When HREADY=1, capture HRDATA[15:0] into shadow[k]. Then go to DONE if k==2, otherwise k++ and go to ADDR.
  - DONE: copy all three shadows to the outputs in the same cycle; snap_valid=1 for this cycle; bus_req=0; go to IDLE.
- Bus request: bus_req stays high from REQ through DATA of k=2. The arbiter must not revoke the grant mid-sequence; a grant drop after REQ is ignored.
- Latency: with bus_gnt and HREADY already high, the sequence from IDLE-with-pending to the snap_valid pulse is REQ 1 + 3x(ADDR+DATA) 6 + DONE 1 = 8 cycles. Each HREADY=0 wait state adds 1 cycle.
- Snapshot coherence: outputs never show a mix of old and new registers.
- enable falling mid-sequence: the sequence completes; no new poll starts afterwards.
- irq:
  - Set in DONE if the new fork_count differs from the previous snapshot (16-bit compare, wrap 0xFFFF->0x0000 counts as a change).
  - The first snapshot after reset compares against 0.
  - irq_clr clears irq. If irq_clr and a set occur in the same cycle, the set wins.
- Pending timing: a pending set during a sequence starts the next sequence directly after DONE, via IDLE.

Optional Feature:
- Macro: SENSOR_POLL_STOP_DETECT_EN.
- Defined: adds output `stopped` (1 bit), updated in DONE as (crank_period > STOP_LIMIT) || (fork_period > STOP_LIMIT). irq is also set on any change of `stopped`.
- Undefined: the `stopped` port and logic are absent; irq sources only the fork_count change.

Test Plan:
- Reset and idle: HRESET=1 for 2 cycles, then enable=0 for 100 cycles -> HTRANS stays 00, bus_req=0, all outputs 0, irq=0.
- Single poll_now, gnt=1, HREADY=1, slave returns 0x0005, 0x0123, 0x0456 -> HADDR sequence 0x6000_0000/04/08; snap_valid 8 cycles after the pulse; fork_count=5, crank_period=0x123, fork_period=0x456; irq=1.
- Grant and wait states: bus_gnt delayed 5 cycles, and HREADY=0 for 2 cycles in the DATA phase of k=1 -> snap_valid at cycle 15; HRDATA upper bits 0xFFFF are ignored.
- Periodic polling, POLL_PERIOD=20: snap_valid every 20 cycles. Identical fork_count -> irq stays 0. fork_count 0xFFFF->0x0000 -> irq=1. irq_clr coinciding with a new change -> irq stays 1.
- Coalescing: poll_now pulsed 3 times during one sequence -> exactly one additional sequence follows.
- Reset mid-sequence (in DATA, k=1) -> next cycle HTRANS=00, bus_req=0, outputs 0. With SENSOR_POLL_STOP_DETECT_EN defined and crank_period=3001 -> stopped=1, irq=1.
